// File: rtl/exit_report_pkg.sv
// Shared types and constants for the end-of-test UART status reporter.
// Optional feature macro: EXIT_REPORT_REARM_EN (used by exit_report_uart).
package exit_report_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    localparam int MSG_LEN = 12;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Uppercase hex: 'A' is 0x41 = 0x37 + 10.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake and a registered TX line.
// Accepts the next byte during the last stop-bit cycle so characters go back to back.
module uart_tx_byte
    import exit_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       idle_line,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             bit_end;

    assign bit_end = (cnt_reg == CNT_LAST);
    assign ready   = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
    assign tx      = tx_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        if (state_reg != IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        end
        case (state_reg)
            IDLE: tx_next = idle_line;
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = idle_line;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new byte always wins: the start bit goes out on the very next cycle.
        if (valid && ready) begin
            state_next = START;
            cnt_next   = '0;
            shift_next = data;
            tx_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

endmodule

// File: rtl/exit_report_uart.sv
// Prints "<P|F|E> XXXXXXXX\r\n" on the UART once the test wrapper signals an exit.
// Define EXIT_REPORT_REARM_EN to return to pass-through after each report.
module exit_report_uart
    import exit_report_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 5000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    input  logic        tests_passed_i,
    input  logic        tests_failed_i,
    input  logic        core_tx_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("exit_report_uart: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    // START here spans the whole character sequence; bit phases live in the serializer.
    state_t      state_reg, state_next;
    logic [31:0] value_reg, value_next;
    logic [3:0]  idx_reg, idx_next;
    logic [7:0]  hex_chars [8];
    logic [7:0]  status_now;
    logic [7:0]  char_sel;
    logic [7:0]  ser_data;
    logic        event_any;
    logic        ser_valid;
    logic        ser_ready;
    logic        idle_line;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hex
            assign hex_chars[gi] = nibble_to_ascii(value_reg[31-4*gi -: 4]);
        end
    endgenerate

    assign event_any  = exit_valid_i | tests_passed_i | tests_failed_i;
    assign status_now = tests_failed_i ? CH_F : (tests_passed_i ? CH_P : CH_E);

    always_comb begin
        case (idx_reg)
            4'd0:    char_sel = status_now;
            4'd1:    char_sel = CH_SP;
            4'd10:   char_sel = CH_CR;
            4'd11:   char_sel = CH_LF;
            default: char_sel = hex_chars[3'(idx_reg - 4'd2)];
        endcase
    end

    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        idx_next   = idx_reg;
        ser_valid  = 1'b0;
        ser_data   = char_sel;
        idle_line  = 1'b1;
        case (state_reg)
            IDLE: begin
                idle_line = core_tx_i;
                // Character 0 is handed over in the trigger cycle itself.
                if (event_any) begin
                    ser_valid  = 1'b1;
                    ser_data   = status_now;
                    state_next = START;
                    value_next = exit_valid_i ? exit_value_i : 32'h0;
                    idx_next   = 4'd1;
                end
            end
            START: begin
                if (idx_reg != 4'(MSG_LEN)) begin
                    ser_valid = 1'b1;
                    if (ser_ready) begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else if (ser_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
`ifdef EXIT_REPORT_REARM_EN
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            value_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            idx_reg   <= idx_next;
        end
    end

    assign busy_o = (state_reg == START);
    assign done_o = (state_reg == DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk_i),
        .rst      (rst_i),
        .valid    (ser_valid),
        .data     (ser_data),
        .idle_line(idle_line),
        .ready    (ser_ready),
        .tx       (tx_o)
    );

endmodule

// File: tb/tb_exit_report_uart.sv
// Self-checking bench for exit_report_uart at 4 clocks per UART bit.
// Expected lines are built from the message format and 8N1 framing rules.
module tb_exit_report_uart;

    localparam int CLK_FREQ_HZ = 1000000;
    localparam int BAUD        = 250000;
    localparam int CPB         = 4;
    localparam int NCHAR       = 12;
    localparam int FRAME       = 10 * CPB;
    localparam int MSG_CYC     = NCHAR * FRAME;

    typedef logic [NCHAR-1:0][7:0] msg_t;

    typedef struct {
        logic        fail;
        logic        pass;
        logic        ev;
        logic [31:0] val;
        logic [7:0]  exp_st;
        logic [31:0] exp_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = 32'h0;
    logic        tests_passed_i = 1'b0;
    logic        tests_failed_i = 1'b0;
    logic        core_tx_i = 1'b1;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int   checks = 0;
    int   errors = 0;
    logic cap [MSG_CYC];
    vec_t tbl [5];

    always #5 clk = ~clk;

    exit_report_uart #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .exit_valid_i  (exit_valid_i),
        .exit_value_i  (exit_value_i),
        .tests_passed_i(tests_passed_i),
        .tests_failed_i(tests_failed_i),
        .core_tx_i     (core_tx_i),
        .tx_o          (tx_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic msg_t build_msg(input logic [7:0] st, input logic [31:0] v);
        msg_t  m;
        string hexd = "0123456789ABCDEF";
        m[0] = st;
        m[1] = 8'h20;
        for (int i = 0; i < 8; i++) begin
            m[2+i] = hexd[int'(v[31-4*i -: 4])];
        end
        m[10] = 8'h0D;
        m[11] = 8'h0A;
        return m;
    endfunction

    function automatic msg_t model_msg(input logic fail, input logic pass, input logic ev,
                                       input logic [31:0] val);
        logic [7:0] st;
        st = fail ? 8'h46 : (pass ? 8'h50 : 8'h45);
        return build_msg(st, ev ? val : 32'h0);
    endfunction

    task automatic apply_reset(input string tag);
        @(negedge clk);
        tests_failed_i = 1'b0;
        tests_passed_i = 1'b0;
        exit_valid_i   = 1'b0;
        rst_i          = 1'b1;
        #1;
        check({tag, " rst tx"},   32'(tx_o),   32'h1);
        check({tag, " rst busy"}, 32'(busy_o), 32'h0);
        check({tag, " rst done"}, 32'(done_o), 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Leaves the bench on the negedge right after the trigger edge.
    task automatic fire(input logic f, input logic p, input logic e, input logic [31:0] v);
        @(negedge clk);
        tests_failed_i = f;
        tests_passed_i = p;
        exit_valid_i   = e;
        exit_value_i   = v;
        @(negedge clk);
        tests_failed_i = 1'b0;
        tests_passed_i = 1'b0;
        exit_valid_i   = 1'b0;
    endtask

    task automatic passthru(input int n, input string tag);
        logic prev;
        int   bad = 0;
        @(negedge clk);
        prev = 1'($urandom);
        core_tx_i = prev;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_o !== prev) bad++;
            prev = 1'($urandom);
            core_tx_i = prev;
        end
        check({tag, " passthru mismatches"}, 32'(bad), 32'h0);
    endtask

    task automatic capture_and_check(input msg_t m, input int inject_at, input string tag);
        int         bad = 0;
        int         busy_cnt = 0;
        int         ch;
        int         pos;
        logic       eb;
        logic [7:0] d;
        for (int k = 0; k < MSG_CYC; k++) begin
            cap[k] = tx_o;
            if (busy_o === 1'b1) busy_cnt++;
            ch  = k / FRAME;
            pos = (k % FRAME) / CPB;
            eb  = (pos == 0) ? 1'b0 : ((pos == 9) ? 1'b1 : m[ch][pos-1]);
            if (cap[k] !== eb) bad++;
            core_tx_i      = 1'($urandom);
            tests_passed_i = (k == inject_at);
            @(negedge clk);
        end
        tests_passed_i = 1'b0;
        check({tag, " wave mismatches"}, 32'(bad), 32'h0);
        for (int i = 0; i < NCHAR; i++) begin
            for (int b = 0; b < 8; b++) begin
                d[b] = cap[i*FRAME + (b+1)*CPB + CPB/2];
            end
            check($sformatf("%s char%0d", tag, i), 32'(d), 32'(m[i]));
        end
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(MSG_CYC));
        check({tag, " busy end"},    32'(busy_o),   32'h0);
        check({tag, " done"},        32'(done_o),   32'h1);
    endtask

    initial begin
        msg_t m;
        logic f, p, e;
        logic [31:0] v;
        int bad;

        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h0000002A, 8'h50, 32'h0000002A};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h12345678, 8'h46, 32'h00000000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'h45, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0F1E2D3C, 8'h46, 32'h0F1E2D3C};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h50, 32'h00000000};

        apply_reset("init");
        passthru(24, "pre-trigger");

        for (int i = 0; i < 5; i++) begin
            apply_reset($sformatf("vec%0d", i));
            passthru(4, $sformatf("vec%0d", i));
            fire(tbl[i].fail, tbl[i].pass, tbl[i].ev, tbl[i].val);
            capture_and_check(build_msg(tbl[i].exp_st, tbl[i].exp_val), -1,
                              $sformatf("vec%0d", i));
        end

        // Pass pulse mid-report is dropped; then a pulse after completion.
        apply_reset("drop");
        fire(1'b0, 1'b1, 1'b1, 32'h00000055);
        capture_and_check(build_msg(8'h50, 32'h55), 100, "drop");
        @(negedge clk);
`ifdef EXIT_REPORT_REARM_EN
        check("rearm done pulse", 32'(done_o), 32'h0);
        fire(1'b0, 1'b1, 1'b0, 32'hABCDEF01);
        capture_and_check(build_msg(8'h50, 32'h0), -1, "rearm");
`else
        check("sticky done", 32'(done_o), 32'h1);
        fire(1'b0, 1'b1, 1'b0, 32'hABCDEF01);
        bad = 0;
        for (int k = 0; k < MSG_CYC + 40; k++) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b1) bad++;
            core_tx_i = 1'($urandom);
            @(negedge clk);
        end
        check("terminal done ignores events", 32'(bad), 32'h0);
`endif

        // Reset in the middle of character 5 abandons the report immediately.
        apply_reset("abort");
        fire(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        for (int k = 0; k < 5*FRAME + 2*CPB + 1; k++) begin
            core_tx_i = 1'($urandom);
            @(negedge clk);
        end
        rst_i = 1'b1;
        #1;
        check("abort tx",   32'(tx_o),   32'h1);
        check("abort busy", 32'(busy_o), 32'h0);
        check("abort done", 32'(done_o), 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        passthru(4, "after abort");
        fire(1'b0, 1'b1, 1'b1, 32'h00C0FFEE);
        capture_and_check(build_msg(8'h50, 32'h00C0FFEE), -1, "after abort");

        for (int r = 0; r < 6; r++) begin
            apply_reset($sformatf("rand%0d", r));
            {f, p, e} = 3'($urandom_range(1, 7));
            v = $urandom;
            m = model_msg(f, p, e, v);
            fire(f, p, e, v);
            capture_and_check(m, -1, $sformatf("rand%0d f%0b p%0b e%0b v%08h", r, f, p, e, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
